// File: rtl/uc_pkg.sv
// Shared definitions for the uc_int control unit: opcode constants, WD3 source
// encodings, FSM state type and opcode classification helpers.
package uc_pkg;

    localparam logic [5:0] OP_IN   = 6'b100100;
    localparam logic [5:0] OP_OUT  = 6'b100101;
    localparam logic [5:0] OP_PUSH = 6'b100110;
    localparam logic [5:0] OP_POP  = 6'b100111;
    localparam logic [5:0] OP_J    = 6'b101000;
    localparam logic [5:0] OP_JZ   = 6'b101001;
    localparam logic [5:0] OP_JNZ  = 6'b101010;
    localparam logic [5:0] OP_JAL  = 6'b101011;
    localparam logic [5:0] OP_RET  = 6'b101100;
    localparam logic [5:0] OP_RETI = 6'b101101;
    localparam logic [5:0] OP_EI   = 6'b101110;
    localparam logic [5:0] OP_DI   = 6'b101111;
    localparam logic [5:0] OP_NOP  = 6'b110000;

    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_PORT  = 2'b01;
    localparam logic [1:0] SEL_STACK = 2'b10;
    localparam logic [1:0] SEL_INM   = 2'b11;

    localparam int HOLD_W = 3;

    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } uc_state_e;

    // Instructions that redirect the PC; an interrupt is never taken on them.
    function automatic logic is_ctrl_flow(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JZ) || (op == OP_JNZ) ||
               (op == OP_JAL) || (op == OP_RET) || (op == OP_RETI);
    endfunction

    // 0xxxxx and 10xxxx are fully mapped; only NOP lives in 11xxxx.
    function automatic logic is_undefined(input logic [5:0] op);
        return (op[5:4] == 2'b11) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/uc_int_fsm.sv
// Interrupt machinery: ie, pend, holdoff and RUN/ISR state plus accept logic.
// UC_ILLEGAL_TRAP_EN makes undefined opcodes take the accept sequence.
module uc_int_fsm
    import uc_pkg::*;
#(
    parameter int HOLDOFF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       s_interruption,
    output logic       accept,
    output logic       reti_exec,
    output logic       state_dbg
);

    uc_state_e         state, state_next;
    logic              ie;
    logic              pend;
    logic [HOLD_W-1:0] holdoff;
    logic              accept_int;
    logic              trap;

    // s_interruption may be a pulse or a level; any high cycle is remembered in pend.
    assign accept_int = reset && (state == RUN) && (pend || s_interruption) &&
                        ie && (holdoff == '0) && !is_ctrl_flow(opcode);

`ifdef UC_ILLEGAL_TRAP_EN
    assign trap = reset && is_undefined(opcode);
`else
    assign trap = 1'b0;
`endif

    assign accept    = accept_int || trap;
    assign reti_exec = reset && (state == ISR) && (opcode == OP_RETI);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        if (accept)
            state_next = ISR;
        else if (reti_exec)
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            ie      <= 1'b0;
            pend    <= 1'b0;
            holdoff <= '0;
        end else begin
            state <= state_next;

            if (opcode == OP_EI)
                ie <= 1'b1;
            else if (opcode == OP_DI)
                ie <= 1'b0;

            // A pure illegal-opcode trap leaves a latched request for later service.
            if (accept_int)
                pend <= 1'b0;
            else if (s_interruption)
                pend <= 1'b1;

            if (reti_exec)
                holdoff <= HOLD_W'(HOLDOFF);
            else if ((state == RUN) && (holdoff != '0))
                holdoff <= holdoff - 1'b1;
        end
    end

endmodule

// File: rtl/uc_int.sv
// Control unit top: combinational instruction decoder with interrupt overrides
// from uc_int_fsm. Optional feature macro: UC_ILLEGAL_TRAP_EN.
module uc_int
    import uc_pkg::*;
#(
    parameter int HOLDOFF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       s_interruption,
    output logic       s_4mux1,
    output logic       s_4mux2,
    output logic       s_4mux3,
    output logic       we3,
    output logic       wez,
    output logic       s_we_port,
    output logic       s_we_stack,
    output logic       s_jalret,
    output logic       s_we_stack_data,
    output logic       s_pushpop,
    output logic [2:0] op_alu,
    output logic [1:0] sel_inputs,
    output logic       int_ack,
    output logic       int_done,
    output logic       in_isr
);

    logic accept;
    logic reti_exec;
    logic state_dbg;

    uc_int_fsm #(
        .HOLDOFF(HOLDOFF)
    ) u_fsm (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .s_interruption(s_interruption),
        .accept        (accept),
        .reti_exec     (reti_exec),
        .state_dbg     (state_dbg)
    );

    // The only state bit is ISR vs RUN, so it doubles as the in_isr flag.
    assign in_isr = state_dbg;

    always_comb begin
        s_4mux1         = 1'b1;
        s_4mux2         = 1'b0;
        s_4mux3         = 1'b0;
        we3             = 1'b0;
        wez             = 1'b0;
        s_we_port       = 1'b0;
        s_we_stack      = 1'b0;
        s_jalret        = 1'b0;
        s_we_stack_data = 1'b0;
        s_pushpop       = 1'b0;
        op_alu          = 3'b000;
        sel_inputs      = SEL_ALU;
        int_ack         = 1'b0;
        int_done        = 1'b0;

        if (!opcode[5]) begin
            op_alu = opcode[4:2];
            we3    = 1'b1;
            wez    = 1'b1;
        end else if (opcode[5:2] == 4'b1000) begin
            we3        = 1'b1;
            sel_inputs = SEL_INM;
        end else begin
            case (opcode)
                OP_IN: begin
                    we3        = 1'b1;
                    sel_inputs = SEL_PORT;
                end
                OP_OUT: s_we_port = 1'b1;
                OP_PUSH: begin
                    s_we_stack_data = 1'b1;
                    s_pushpop       = 1'b1;
                end
                OP_POP: begin
                    s_we_stack_data = 1'b1;
                    we3             = 1'b1;
                    sel_inputs      = SEL_STACK;
                end
                OP_J: begin
                    s_4mux1 = 1'b0;
                    s_4mux2 = 1'b1;
                end
                OP_JZ: begin
                    if (z) begin
                        s_4mux1 = 1'b0;
                        s_4mux2 = 1'b1;
                    end
                end
                OP_JNZ: begin
                    if (!z) begin
                        s_4mux1 = 1'b0;
                        s_4mux2 = 1'b1;
                    end
                end
                OP_JAL: begin
                    s_4mux1    = 1'b0;
                    s_4mux2    = 1'b1;
                    s_we_stack = 1'b1;
                    s_jalret   = 1'b1;
                end
                OP_RET, OP_RETI: begin
                    s_4mux3    = 1'b1;
                    s_we_stack = 1'b1;
                end
                default: ;
            endcase
        end

        int_done = reti_exec;

        // Accept never coincides with a control-flow opcode, so no stack clash.
        if (accept) begin
            s_we_stack = 1'b1;
            s_jalret   = 1'b1;
            s_4mux1    = 1'b0;
            s_4mux2    = 1'b0;
            int_ack    = 1'b1;
        end

        if (!reset) begin
            s_4mux1         = 1'b1;
            s_4mux2         = 1'b0;
            s_4mux3         = 1'b0;
            we3             = 1'b0;
            wez             = 1'b0;
            s_we_port       = 1'b0;
            s_we_stack      = 1'b0;
            s_jalret        = 1'b0;
            s_we_stack_data = 1'b0;
            s_pushpop       = 1'b0;
            op_alu          = 3'b000;
            sel_inputs      = SEL_ALU;
            int_ack         = 1'b0;
            int_done        = 1'b0;
        end
    end

endmodule
